// File: rtl/ysyx_25040101_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read per instruction and
// hands the fetched word plus its PC to decode; strictly one request in flight.
module ysyx_25040101_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] next_pc_i,
    input  logic        next_pc_valid_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    output logic        imem_resp_ready_o,
    input  logic [31:0] imem_resp_data_i,
    input  logic        imem_resp_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    logic        misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ: begin
                // A misaligned PC faults locally and never reaches memory.
                if (misaligned)            state_nxt = S_HOLD;
                else if (imem_req_ready_i) state_nxt = S_WAIT;
            end
            S_WAIT:  if (imem_resp_valid_i) state_nxt = S_HOLD;
            S_HOLD:  if (inst_ready_i)      state_nxt = S_EXEC;
            S_EXEC:  if (next_pc_valid_i)   state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc   <= RESET_PC;
            inst <= '0;
            err  <= 1'b0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (misaligned) begin
                        inst <= '0;
                        err  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid_i) begin
                        inst <= imem_resp_data_i;
                        err  <= imem_resp_err_i;
                    end
                end
                S_EXEC: begin
                    if (next_pc_valid_i) pc <= next_pc_i;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are decoded from state only; reset masks them off.
    always_comb begin
        imem_req_valid_o  = 1'b0;
        imem_resp_ready_o = 1'b0;
        inst_valid_o      = 1'b0;
        if (!reset) begin
            unique case (state)
                S_REQ:   imem_req_valid_o  = !misaligned;
                S_WAIT:  imem_resp_ready_o = 1'b1;
                S_HOLD:  inst_valid_o      = 1'b1;
                default: ;
            endcase
        end
    end

    assign imem_req_addr_o = pc;
    assign pc_o            = pc;
    assign inst_o          = inst;
    assign fetch_err_o     = err;

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Bench for the fetch unit: directed cycle table, a loop-period sequence and a
// randomized run against a transaction-level memory/decode/commit model.
module tb_ysyx_25040101_ifu;

    localparam logic [31:0] R = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_pc_i = '0;
    logic        next_pc_valid_i = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic        imem_resp_ready_o;
    logic [31:0] imem_resp_data_i = '0;
    logic        imem_resp_err_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        fetch_err_o;

    ysyx_25040101_ifu #(.RESET_PC(R)) dut (
        .clock(clock), .reset(reset),
        .next_pc_i(next_pc_i), .next_pc_valid_i(next_pc_valid_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o),
        .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_ready_o(imem_resp_ready_o),
        .imem_resp_data_i(imem_resp_data_i), .imem_resp_err_i(imem_resp_err_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .pc_o(pc_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, rqr, rsv;
        logic [31:0] rsd;
        logic        rse, ir, npv;
        logic [31:0] np;
        logic        erq;
        logic [31:0] ea;
        logic        ers, eiv;
        logic [31:0] ei, ep;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic rqr, logic rsv, logic [31:0] rsd, logic rse,
                                logic ir, logic npv, logic [31:0] np,
                                logic erq, logic [31:0] ea, logic ers, logic eiv,
                                logic [31:0] ei, logic [31:0] ep, logic ee);
        vecs.push_back('{rst, rqr, rsv, rsd, rse, ir, npv, np, erq, ea, ers, eiv, ei, ep, ee});
    endfunction

    // Memory contents and faults are a fixed function of the address.
    function automatic logic [31:0] mem_data(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction
    function automatic logic mem_err(logic [31:0] a);
        return a[6:2] == 5'h1f;
    endfunction

    task automatic zero_inputs();
        next_pc_i = '0; next_pc_valid_i = 1'b0; imem_req_ready_i = 1'b0;
        imem_resp_valid_i = 1'b0; imem_resp_data_i = '0; imem_resp_err_i = 1'b0;
        inst_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        zero_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] gen_target(logic [31:0] cur);
        int unsigned r;
        logic [31:0] t;
        r = $urandom_range(0, 15);
        t = $urandom;
        if (r < 10)      return cur + 32'd4;
        else if (r < 14) return {t[31:2], 2'b00};
        else             return {t[31:2], 2'($urandom_range(1, 3))};
    endfunction

    logic [31:0] D, A, B, C, M, J;
    int          hs_cyc[$];
    logic [31:0] hs_addr[$];
    logic [31:0] exp_pc, paddr, sv_addr, sv_inst, sv_pc;
    logic        pend, in_exec, fetched, req_stall, inst_stall, sv_err, stuck;
    int          pdelay, ewait, idle, n_inst;

    initial begin
        D = 32'h0000_0013; A = 32'h00a0_0093; B = 32'hDEAD_BEEF;
        C = 32'h0000_0517; M = 32'h8000_0102; J = 32'h8000_0200;
        //   rst rqr rsv rsd rse ir npv np            erq ea     ers eiv ei ep    ee
        add(1, 0, 0, 0, 0, 0, 0, 0,                  0, R,     0, 0, 0, R,     0);
        add(0, 1, 0, 0, 0, 0, 0, 0,                  1, R,     0, 0, 0, R,     0);
        add(0, 0, 1, D, 0, 0, 0, 0,                  0, R,     1, 0, 0, R,     0);
        add(0, 0, 0, 0, 0, 1, 0, 0,                  0, R,     0, 1, D, R,     0);
        add(0, 0, 0, 0, 0, 0, 1, R+4,                0, R,     0, 0, D, R,     0);
        add(0, 1, 0, 0, 0, 0, 0, 0,                  1, R+4,   0, 0, D, R+4,   0);
        add(0, 0, 1, D, 0, 0, 0, 0,                  0, R+4,   1, 0, D, R+4,   0);
        add(0, 0, 0, 0, 0, 1, 0, 0,                  0, R+4,   0, 1, D, R+4,   0);
        add(0, 0, 0, 0, 0, 0, 1, R+8,                0, R+4,   0, 0, D, R+4,   0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0,              1, R+8,   0, 0, D, R+8,   0);
        add(0, 1, 0, 0, 0, 0, 0, 0,                  1, R+8,   0, 0, D, R+8,   0);
        add(0, 0, 1, A, 0, 0, 0, 0,                  0, R+8,   1, 0, D, R+8,   0);
        add(0, 0, 0, 0, 0, 0, 0, 0,                  0, R+8,   0, 1, A, R+8,   0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h1234_5678,      0, R+8,   0, 1, A, R+8,   0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0,              0, R+8,   0, 1, A, R+8,   0);
        add(0, 0, 0, 0, 0, 1, 1, 0,                  0, R+8,   0, 1, A, R+8,   0);
        add(0, 0, 0, 0, 0, 0, 0, 0,                  0, R+8,   0, 0, A, R+8,   0);
        add(0, 0, 0, 0, 0, 0, 1, M,                  0, R+8,   0, 0, A, R+8,   0);
        add(0, 1, 0, 0, 0, 0, 0, 0,                  0, M,     0, 0, A, M,     0);
        add(0, 0, 0, 0, 0, 0, 0, 0,                  0, M,     0, 1, 0, M,     1);
        add(0, 0, 0, 0, 0, 1, 0, 0,                  0, M,     0, 1, 0, M,     1);
        add(0, 0, 0, 0, 0, 0, 1, J,                  0, M,     0, 0, 0, M,     1);
        add(0, 1, 0, 0, 0, 0, 0, 0,                  1, J,     0, 0, 0, J,     1);
        add(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_0000,      0, J,     1, 0, 0, J,     1);
        add(0, 0, 1, B, 1, 0, 0, 0,                  0, J,     1, 0, 0, J,     1);
        add(0, 0, 0, 0, 0, 1, 0, 0,                  0, J,     0, 1, B, J,     1);
        add(0, 0, 0, 0, 0, 0, 1, J+4,                0, J,     0, 0, B, J,     1);
        add(0, 1, 0, 0, 0, 0, 0, 0,                  1, J+4,   0, 0, B, J+4,   1);
        add(1, 0, 0, 0, 0, 0, 0, 0,                  0, J+4,   0, 0, B, J+4,   1);
        add(0, 0, 1, 32'h1111_1111, 1, 0, 0, 0,      1, R,     0, 0, 0, R,     0);
        add(0, 1, 0, 0, 0, 0, 0, 0,                  1, R,     0, 0, 0, R,     0);
        add(0, 0, 1, C, 0, 0, 0, 0,                  0, R,     1, 0, 0, R,     0);
        add(0, 0, 0, 0, 0, 0, 0, 0,                  0, R,     0, 1, C, R,     0);
        add(1, 0, 0, 0, 0, 1, 0, 0,                  0, R,     0, 0, C, R,     0);
        add(0, 0, 0, 0, 0, 0, 0, 0,                  1, R,     0, 0, 0, R,     0);

        // Directed table: inputs applied after the falling edge, outputs checked before the rising edge.
        zero_inputs();
        repeat (2) @(posedge clock);
        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst;            imem_req_ready_i = vecs[i].rqr;
            imem_resp_valid_i = vecs[i].rsv; imem_resp_data_i = vecs[i].rsd;
            imem_resp_err_i = vecs[i].rse;   inst_ready_i = vecs[i].ir;
            next_pc_valid_i = vecs[i].npv;   next_pc_i = vecs[i].np;
            #1;
            check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid_o), 32'(vecs[i].erq));
            check($sformatf("v%0d_req_addr", i), imem_req_addr_o, vecs[i].ea);
            check($sformatf("v%0d_resp_ready", i), 32'(imem_resp_ready_o), 32'(vecs[i].ers));
            check($sformatf("v%0d_inst_valid", i), 32'(inst_valid_o), 32'(vecs[i].eiv));
            check($sformatf("v%0d_inst", i), inst_o, vecs[i].ei);
            check($sformatf("v%0d_pc", i), pc_o, vecs[i].ep);
            check($sformatf("v%0d_err", i), 32'(fetch_err_o), 32'(vecs[i].ee));
        end

        // Zero-wait memory and decode: one request every 4 cycles at PC, PC+4, ...
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            imem_req_ready_i = 1'b1; imem_resp_valid_i = 1'b1; imem_resp_data_i = D;
            imem_resp_err_i = 1'b0; inst_ready_i = 1'b1;
            next_pc_valid_i = 1'b1; next_pc_i = pc_o + 32'd4;
            if (imem_req_valid_o) begin
                hs_cyc.push_back(c);
                hs_addr.push_back(imem_req_addr_o);
            end
        end
        check("loop_req_count", 32'(hs_cyc.size()), 32'd4);
        foreach (hs_cyc[i]) begin
            check($sformatf("loop_addr%0d", i), hs_addr[i], R + 32'(4 * i));
            check($sformatf("loop_gap%0d", i), 32'(hs_cyc[i] - hs_cyc[0]), 32'(4 * i));
        end

        // Randomized run against the transaction-level model.
        do_reset();
        exp_pc = R; pend = 0; in_exec = 0; fetched = 0; req_stall = 0; inst_stall = 0;
        pdelay = 0; ewait = 0; idle = 0; n_inst = 0; stuck = 0;
        sv_addr = '0; sv_inst = '0; sv_pc = '0; sv_err = 0; paddr = '0;
        for (int c = 0; c < 3000 && !stuck; c++) begin
            @(negedge clock);
            if (req_stall) begin
                check("req_held_valid", 32'(imem_req_valid_o), 32'd1);
                check("req_held_addr", imem_req_addr_o, sv_addr);
            end
            if (inst_stall) begin
                check("inst_held_valid", 32'(inst_valid_o), 32'd1);
                check("inst_held_inst", inst_o, sv_inst);
                check("inst_held_pc", pc_o, sv_pc);
                check("inst_held_err", 32'(fetch_err_o), 32'(sv_err));
            end
            if (pend || in_exec || fetched) check("no_extra_req", 32'(imem_req_valid_o), 32'd0);
            if (pend) check("resp_ready_when_waiting", 32'(imem_resp_ready_o), 32'd1);
            if (pend || in_exec) check("no_inst_while_busy", 32'(inst_valid_o), 32'd0);

            if (pend && pdelay == 0) begin
                imem_resp_valid_i = 1'b1;
                imem_resp_data_i = mem_data(paddr);
                imem_resp_err_i = mem_err(paddr);
                if (imem_resp_ready_o) pend = 0;
            end else if (pend) begin
                pdelay--;
                imem_resp_valid_i = 1'b0;
                imem_resp_data_i = $urandom;
            end else begin
                imem_resp_valid_i = ($urandom_range(0, 3) == 0);
                imem_resp_data_i = $urandom;
                imem_resp_err_i = 1'($urandom_range(0, 1));
            end

            imem_req_ready_i = ($urandom_range(0, 3) != 0);
            if (imem_req_valid_o && imem_req_ready_i) begin
                check("req_addr", imem_req_addr_o, exp_pc);
                fetched = 1; pend = 1; paddr = exp_pc;
                pdelay = $urandom_range(0, 3);
            end

            if (in_exec) begin
                if (ewait == 0) begin
                    next_pc_valid_i = 1'b1;
                    next_pc_i = gen_target(exp_pc);
                    exp_pc = next_pc_i;
                    in_exec = 0;
                end else begin
                    ewait--;
                    next_pc_valid_i = 1'b0;
                end
            end else begin
                next_pc_valid_i = ($urandom_range(0, 3) == 0);
                next_pc_i = $urandom;
            end

            inst_ready_i = ($urandom_range(0, 2) != 0);
            if (inst_valid_o && inst_ready_i) begin
                check("inst_pc", pc_o, exp_pc);
                if (exp_pc[1:0] != 2'b00) begin
                    check("inst_misaligned_word", inst_o, 32'd0);
                    check("inst_misaligned_err", 32'(fetch_err_o), 32'd1);
                end else begin
                    check("inst_word", inst_o, mem_data(exp_pc));
                    check("inst_err", 32'(fetch_err_o), 32'(mem_err(exp_pc)));
                    check("inst_was_fetched", 32'(fetched), 32'd1);
                end
                in_exec = 1; fetched = 0; ewait = $urandom_range(0, 3);
                n_inst++; idle = 0;
            end else begin
                idle++;
                if (idle > 100) begin
                    n_cmp++; n_bad++;
                    $display("FAIL progress: %0d cycles without an instruction, required at most 100", idle);
                    stuck = 1;
                end
            end

            req_stall = imem_req_valid_o && !imem_req_ready_i;
            sv_addr = imem_req_addr_o;
            inst_stall = inst_valid_o && !inst_ready_i;
            sv_inst = inst_o; sv_pc = pc_o; sv_err = fetch_err_o;
        end
        check("random_inst_count_min", 32'(n_inst >= 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
